// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-road (NS / EW) intersection controller. A free-running prescaler
//   produces a one-cycle tick every CLK_DIV clocks. An 8-bit phase timer
//   counts ticks within each phase. Crossing requests are latched and may
//   end a green early once it has run MIN_GREEN_T ticks. Every change of
//   right-of-way passes through yellow and an all-red clearance.
//
//   Optional build macro: TL_FLASH_EN adds the `flash` input and a FLASH
//   state (NS flashes yellow, EW flashes red). FLASH is entered from the end
//   of an all-red phase and left through AR_TO_NS.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   req[1:0]     req[0] asks for NS green, req[1] asks for EW green
//   flash        night-flash request (TL_FLASH_EN builds only)
//   Light_NS     NS head RGB (red 100, yellow 110, green 010, off 000)
//   Light_EW     EW head RGB, same encoding
//   phase        current state code
//   req_pending  latched requests
module traffic_light_ctrl #(
    parameter int CLK_DIV     = 100_000_000,
    parameter int GREEN_T     = 10,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 1,
    parameter int MIN_GREEN_T = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
`ifdef TL_FLASH_EN
    input  logic       flash,
`endif
    output logic [2:0] Light_NS,
    output logic [2:0] Light_EW,
    output logic [2:0] phase,
    output logic [1:0] req_pending
);

    localparam int             PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [7:0]     GREEN_M1  = 8'(GREEN_T - 1);
    localparam logic [7:0]     YELLOW_M1 = 8'(YELLOW_T - 1);
    localparam logic [7:0]     ALLRED_M1 = 8'(ALLRED_T - 1);
    localparam logic [7:0]     MIN_M1    = 8'(MIN_GREEN_T - 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b110;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] OFF = 3'b000;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        AR_TO_EW  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        AR_TO_NS  = 3'd5
`ifdef TL_FLASH_EN
        , FLASH   = 3'd6
`endif
    } state_t;

    // The state register is kept as raw bits so that every 3-bit code,
    // including the illegal ones, is representable and decodes explicitly.
    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    pend_q, pend_d;
    logic          tick;
    logic [7:0]    dur_m1;
    logic          done;
    logic          early;
`ifdef TL_FLASH_EN
    logic          tog_q, tog_d;
`endif

    // ---------------- prescaler ----------------
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // ---------------- next state / timer ----------------
    always_comb begin
        case (state_q)
            NS_GREEN, EW_GREEN:   dur_m1 = GREEN_M1;
            NS_YELLOW, EW_YELLOW: dur_m1 = YELLOW_M1;
            default:              dur_m1 = ALLRED_M1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done    = (timer_q == dur_m1);
        early   = (timer_q >= MIN_M1);
        case (state_q)
            NS_GREEN:  if (tick && (done || (pend_q[1] && early))) state_d = NS_YELLOW;
            NS_YELLOW: if (tick && done) state_d = AR_TO_EW;
`ifdef TL_FLASH_EN
            AR_TO_EW:  if (tick && done) state_d = flash ? FLASH : EW_GREEN;
`else
            AR_TO_EW:  if (tick && done) state_d = EW_GREEN;
`endif
            EW_GREEN:  if (tick && (done || (pend_q[0] && early))) state_d = EW_YELLOW;
            EW_YELLOW: if (tick && done) state_d = AR_TO_NS;
`ifdef TL_FLASH_EN
            AR_TO_NS:  if (tick && done) state_d = flash ? FLASH : NS_GREEN;
            FLASH:     if (tick && !flash) state_d = AR_TO_NS;
`else
            AR_TO_NS:  if (tick && done) state_d = NS_GREEN;
`endif
            // Illegal codes fall into the all-red phase that leads to NS.
            default:   state_d = AR_TO_NS;
        endcase

        timer_d = timer_q;
        if (state_d != state_q) timer_d = '0;
        else if (tick)          timer_d = timer_q + 1'b1;
`ifdef TL_FLASH_EN
        if (state_q == FLASH) timer_d = '0;
`endif
    end

    // ---------------- request latch ----------------
    // Clearing on green entry is applied after the set so it wins a tie.
    always_comb begin
        pend_d = pend_q;
        if (req[0] && state_q != NS_GREEN) pend_d[0] = 1'b1;
        if (req[1] && state_q != EW_GREEN) pend_d[1] = 1'b1;
        if (state_d == NS_GREEN && state_q != NS_GREEN) pend_d[0] = 1'b0;
        if (state_d == EW_GREEN && state_q != EW_GREEN) pend_d[1] = 1'b0;
`ifdef TL_FLASH_EN
        // Requests are meaningless while flashing; drop them on entry and
        // ignore them until FLASH is left.
        if (state_q == FLASH || state_d == FLASH) pend_d = '0;
`endif
    end

`ifdef TL_FLASH_EN
    // Toggle is forced to 0 outside FLASH so the first FLASH tick period is lit.
    always_comb begin
        tog_d = 1'b0;
        if (state_q == FLASH) tog_d = tick ? ~tog_q : tog_q;
    end
`endif

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            state_q <= NS_GREEN;
            timer_q <= '0;
            pend_q  <= '0;
`ifdef TL_FLASH_EN
            tog_q   <= 1'b0;
`endif
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
`ifdef TL_FLASH_EN
            tog_q   <= tog_d;
`endif
        end
    end

    // ---------------- Moore output decode ----------------
    // Red/red is the default so illegal codes never show a permissive light.
    always_comb begin
        Light_NS = RED;
        Light_EW = RED;
        case (state_q)
            NS_GREEN:  Light_NS = GRN;
            NS_YELLOW: Light_NS = YEL;
            EW_GREEN:  Light_EW = GRN;
            EW_YELLOW: Light_EW = YEL;
`ifdef TL_FLASH_EN
            FLASH: begin
                Light_NS = tog_q ? OFF : YEL;
                Light_EW = tog_q ? OFF : RED;
            end
`endif
            default: ;
        endcase
    end

    assign phase       = state_q;
    assign req_pending = pend_q;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road intersection controller: the next generation of our fixed-timing traffic light FSM. Adds a built-in tick prescaler, parameterised phase durations, all-red clearance phases, latched crossing requests with a minimum-green guarantee, and an optional night-flash mode. Sits between the board clock/reset and the RGB light drivers for the North/South (NS) and East/West (EW) heads.

## Interface
- CLK_DIV, 100_000_000: clock cycles per timing tick (≥2); 1 s at 100 MHz.
- GREEN_T, 10: green duration in ticks (1..255).
- YELLOW_T, 3: yellow duration in ticks (1..255).
- ALLRED_T, 1: all-red clearance duration in ticks (1..255).
- MIN_GREEN_T, 4: minimum green ticks before a request may cut green short (1..GREEN_T).

- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- req  in  2  req[0] requests NS green, req[1] requests EW green; level-sampled every cycle.
- flash  in  1  night-flash request (present only with TL_FLASH_EN).
- Light_NS  out  3  NS RGB: red 3'b100, yellow 3'b110, green 3'b010, off 3'b000.
- Light_EW  out  3  EW RGB, same encoding.
- phase  out  3  current state code (below).
- req_pending  out  2  latched requests.

## Operation
- States/codes: NS_GREEN 0, NS_YELLOW 1, AR_TO_EW 2, EW_GREEN 3, EW_YELLOW 4, AR_TO_NS 5, FLASH 6 (only with TL_FLASH_EN). Codes 7 (and 6 without the macro) are illegal: recover to AR_TO_NS on the next clock.
- Sequence: NS_GREEN → NS_YELLOW → AR_TO_EW → EW_GREEN → EW_YELLOW → AR_TO_NS → NS_GREEN.
- Lights are a Moore decode of the state register: NS_GREEN G/R, NS_YELLOW Y/R, AR_* R/R, EW_GREEN R/G, EW_YELLOW R/Y. Both heads are never non-red simultaneously.
- Prescaler: counts 0..CLK_DIV-1 free-running. `tick` is high in the cycle the count equals CLK_DIV-1. Not reset on state change.
- Phase timer (8 bit): +1 per tick. On a tick with timer == duration-1, the state advances and the timer loads 0.
- Request latch: req_pending[0] sets on any cycle with req[0]=1 and state ≠ NS_GREEN. It clears on the cycle entering NS_GREEN, and clear wins over a simultaneous set. req_pending[1] is the mirror for EW_GREEN.
- Early exit: in EW_GREEN, a tick with req_pending[0]=1 and timer ≥ MIN_GREEN_T-1 advances to EW_YELLOW. NS_GREEN mirrors this with req_pending[1]. If both exit conditions hold on one tick, it is still a single advance.
- Requests never shorten yellow or all-red.
- Reset values: state NS_GREEN, timer 0, prescaler 0, req_pending 2'b00, Light_NS 3'b010, Light_EW 3'b100, phase 0. Reset mid-phase aborts the phase; no clearance is inserted.

## Timing
- Lights and phase change in the same cycle as the state register, which is the cycle after the terminal tick.
- A phase lasts exactly duration×CLK_DIV cycles. The first NS_GREEN after reset lasts GREEN_T×CLK_DIV cycles.
- Full cycle with no requests: 2×(GREEN_T+YELLOW_T+ALLRED_T)×CLK_DIV cycles.
- req needs to be high for only one cycle to be latched.
- The earliest early exit is MIN_GREEN_T×CLK_DIV cycles after green entry.

## Configuration
- TL_FLASH_EN defined:
  - Adds the flash input and the FLASH state.
  - flash is checked only on the terminal tick of AR_TO_EW or AR_TO_NS. If flash=1 there, the next state is FLASH instead of the green phase.
  - In FLASH, a toggle bit flips every tick. Light_NS alternates 3'b110/3'b000 and Light_EW alternates 3'b100/3'b000, both starting lit. The timer is held at 0.
  - On a tick in FLASH with flash=0, the next state is AR_TO_NS.
  - req_pending is cleared on FLASH entry and held at 0 while in FLASH.
- TL_FLASH_EN undefined: no flash port, no FLASH state, code 6 is illegal.

## Test plan
Bench parameters: CLK_DIV=4, GREEN_T=10, YELLOW_T=3, ALLRED_T=1, MIN_GREEN_T=4.
- Free run from reset → NS green for cycles 0–39, NS yellow 40–51, all-red 52–55, EW green from cycle 56; phase returns to 0 at cycle 112.
- One-cycle req[1] pulse at cycle 5 → req_pending=2'b10; NS_YELLOW at cycle 16 (the tick with timer 3); latch clears at EW_GREEN entry.
- req[0] held high throughout EW_GREEN → no exit before 16 cycles into EW_GREEN; exit at exactly 16 cycles; yellow and all-red keep full length.
- Assert reset mid EW_YELLOW → outputs go to G/R and req_pending to 0 asynchronously; the next NS_GREEN lasts 40 cycles.
- Force phase code 7 → AR_TO_NS next clock, lights R/R.
- TL_FLASH_EN: flash=1 during NS_GREEN → no change until the end of AR_TO_EW, then FLASH with lights toggling every 4 cycles; flash=0 → AR_TO_NS for 4 cycles, then NS_GREEN.
